// File: rtl/norm_shift_16b_pkg.sv
// Shared constants for the 16-bit normalizer: widths, FSM encodings and mode encodings.
// Optional NORM_FAST_EN build macro enables 4-bit shift steps (see norm_shift_16b).
package norm_shift_16b_pkg;

    localparam int NORM_W     = 16;
    localparam int NORM_AMT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } norm_state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/norm_shift_16b_detect.sv
// Combinational status of the working register: normalized, degenerate, and four
// redundant top bits (the last one feeds the NORM_FAST_EN 4-bit step).
module norm_detect_16b
    import norm_shift_16b_pkg::*;
(
    input  logic [NORM_W-1:0] value,
    input  logic              mode,
    output logic              is_norm,
    output logic              is_degen,
    output logic              redund4
);

    always_comb begin
        is_norm  = 1'b0;
        is_degen = 1'b0;
        redund4  = 1'b0;
        if (mode == MODE_SIGNED) begin
            is_norm  = value[15] ^ value[14];
            is_degen = (value == 16'h0000) || (value == 16'hFFFF);
            // Five equal sign bits mean four positions can go in one step.
            redund4  = (value[15:11] == 5'b00000) || (value[15:11] == 5'b11111);
        end else begin
            is_norm  = value[15];
            is_degen = (value == 16'h0000);
            redund4  = (value[15:12] == 4'b0000);
        end
    end

endmodule

// File: rtl/norm_shift_16b.sv
// Multi-cycle 16-bit normalizer with start/done handshake; optional NORM_FAST_EN
// macro adds a 4-position step when the top bits are redundant.
//
// Handshake: Start is accepted on any edge where the FSM is IDLE or DONE (Busy=0);
// Done is a one-cycle pulse during which Norm_Out/Norm_Amt/Degen hold the new result,
// and those outputs keep that value until the next Done.
module norm_shift_16b
    import norm_shift_16b_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Signed,
    input  logic [NORM_W-1:0]     Norm_In,
    output logic [NORM_W-1:0]     Norm_Out,
    output logic [NORM_AMT_W-1:0] Norm_Amt,
    output logic                  Degen,
    output logic                  Busy,
    output logic                  Done
);

    norm_state_t           state;
    logic [NORM_W-1:0]     work;
    logic [NORM_AMT_W-1:0] cnt;
    logic                  mode;
    logic                  is_norm;
    logic                  is_degen;
`ifdef NORM_FAST_EN
    logic                  redund4;
`else
    logic                  redund4_unused;
`endif

    norm_detect_16b u_detect (
        .value    (work),
        .mode     (mode),
        .is_norm  (is_norm),
        .is_degen (is_degen),
`ifdef NORM_FAST_EN
        .redund4  (redund4)
`else
        .redund4  (redund4_unused)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            work     <= '0;
            cnt      <= '0;
            mode     <= MODE_UNSIGNED;
            Norm_Out <= '0;
            Norm_Amt <= '0;
            Degen    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        work  <= Norm_In;
                        cnt   <= '0;
                        mode  <= Signed;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // A degenerate operand is caught before any shift, so work/cnt still equal Norm_In/0.
                    if (is_degen || is_norm) begin
                        Norm_Out <= work;
                        Norm_Amt <= cnt;
                        Degen    <= is_degen;
                        state    <= ST_DONE;
                    end
`ifdef NORM_FAST_EN
                    else if (redund4) begin
                        work <= {work[NORM_W-5:0], 4'b0000};
                        cnt  <= cnt + 4'd4;
                    end
`endif
                    else begin
                        work <= {work[NORM_W-2:0], 1'b0};
                        cnt  <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (state == ST_SHIFT);
    assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_norm_shift_16b.sv
// Self-checking bench for norm_shift_16b: reference normalizer model feeds a scoreboard
// queue; latency expectations follow NORM_FAST_EN when it is defined.
module tb_norm_shift_16b;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic        Signed;
    logic [15:0] Norm_In;
    logic [15:0] Norm_Out;
    logic [3:0]  Norm_Amt;
    logic        Degen;
    logic        Busy;
    logic        Done;

    int          errors = 0;
    int          checks = 0;
    logic [20:0] exp_q[$];
    int          lat_q[$];
    logic [20:0] last_exp;

    norm_shift_16b dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .Signed   (Signed),
        .Norm_In  (Norm_In),
        .Norm_Out (Norm_Out),
        .Norm_Amt (Norm_Amt),
        .Degen    (Degen),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Result packed as {value, amount, degenerate}, computed by leading-bit search.
    function automatic logic [20:0] model(input logic sgn, input logic [15:0] v);
        int          hi;
        int          amt;
        logic [15:0] sh;
        hi = 0;
        if (!sgn) begin
            if (v == 16'h0000) return {v, 4'd0, 1'b1};
            for (int i = 0; i < 16; i++) if (v[i]) hi = i;
            amt = 15 - hi;
        end else begin
            if (v == 16'h0000 || v == 16'hFFFF) return {v, 4'd0, 1'b1};
            for (int i = 0; i < 15; i++) if (v[i] != v[15]) hi = i;
            amt = 14 - hi;
        end
        sh = v << amt;
        return {sh, 4'(amt), 1'b0};
    endfunction

    function automatic int latency(input logic [20:0] m);
        int amt;
        amt = int'(m[4:1]);
        if (m[0]) return 2;
`ifdef NORM_FAST_EN
        return amt / 4 + amt % 4 + 2;
`else
        return amt + 2;
`endif
    endfunction

    task automatic issue(input logic sgn, input logic [15:0] val);
        logic [20:0] m;
        m       = model(sgn, val);
        Start   = 1'b1;
        Signed  = sgn;
        Norm_In = val;
        exp_q.push_back(m);
        lat_q.push_back(latency(m));
    endtask

    // Follows one accepted operation; issue() must have been called just after the previous edge.
    task automatic wait_done(input bit hold, input bit chain, input logic csgn, input logic [15:0] cval);
        bit          seen;
        logic [20:0] e;
        int          lat;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                check("busy_c1", 32'(Busy), 32'd1);
                check("hold_prev", 32'({Norm_Out, Norm_Amt, Degen}), 32'(last_exp));
            end
            if (Done) begin
                seen  = 1'b1;
                Start = 1'b0;
                check("busy_at_done", 32'(Busy), 32'd0);
                if (exp_q.size() == 0) begin
                    check("queue_empty", 32'd1, 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    lat = lat_q.pop_front();
                    check("norm_out", 32'(Norm_Out), 32'(e[20:5]));
                    check("norm_amt", 32'(Norm_Amt), 32'(e[4:1]));
                    check("degen", 32'(Degen), 32'(e[0]));
                    check("latency", 32'(cyc), 32'(lat));
                    last_exp = e;
                end
                if (chain) issue(csgn, cval);
            end else if (hold) begin
                Norm_In = 16'($urandom_range(0, 65535));
                Signed  = 1'($urandom_range(0, 1));
            end else begin
                Start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic sgn, input logic [15:0] val);
        @(posedge clk);
        #1;
        issue(sgn, val);
        wait_done(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        bit saw_done;
        rst      = 1'b1;
        Start    = 1'b0;
        Signed   = 1'b0;
        Norm_In  = 16'h0000;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_degen", 32'(Degen), 32'd0);
        check("rst_out", 32'(Norm_Out), 32'd0);
        check("rst_amt", 32'(Norm_Amt), 32'd0);
        rst = 1'b0;

        // Reset while unsigned 0x0001 is mid-shift: the operation is dropped.
        @(posedge clk);
        #1;
        Start   = 1'b1;
        Signed  = 1'b0;
        Norm_In = 16'h0001;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(Busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", 32'(Busy), 32'd0);
        check("mrst_done", 32'(Done), 32'd0);
        check("mrst_out", 32'({Norm_Out, Norm_Amt, Degen}), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (Done) saw_done = 1'b1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);

        // Start and rst together: reset wins.
        Start   = 1'b1;
        Norm_In = 16'h0001;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        Start = 1'b0;
        check("start_vs_rst", 32'(Busy), 32'd0);

        run_op(1'b0, 16'h8000);
        run_op(1'b0, 16'h0001);
        run_op(1'b1, 16'hFF80);
        run_op(1'b1, 16'h0001);
        run_op(1'b1, 16'hFFFF);
        run_op(1'b0, 16'h0000);
        run_op(1'b1, 16'hFFFE);
        run_op(1'b1, 16'h4000);
        run_op(1'b0, 16'h0000);

        // Start held through SHIFT with changing operand must not disturb the result.
        @(posedge clk);
        #1;
        issue(1'b0, 16'h0100);
        wait_done(1'b1, 1'b0, 1'b0, 16'h0000);

        // Back-to-back: new Start in the DONE cycle, outputs hold until the next Done.
        @(posedge clk);
        #1;
        issue(1'b1, 16'h0001);
        wait_done(1'b0, 1'b1, 1'b0, 16'h00F0);
        wait_done(1'b0, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            run_op(1'($urandom_range(0, 1)),
                   16'(32'($urandom_range(0, 65535)) >> $urandom_range(0, 15)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
